// File: rtl/spi_word_bridge.sv
// Clock-domain companion of an SPI slave: captures each new word into a 2-entry rx stream,
// handshakes the new-data flag clear, and refills the slave's tx word from the result stream.
// Optional overrun counter is enabled by defining SPI_WORD_BRIDGE_OVERRUN_CNT_EN.
//
// Handshakes: a beat transfers on the rising clk edge where valid & ready are both high.
// The producer holds valid (and data) until that edge, and ready never depends on a valid
// combinationally.
module spi_word_bridge #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0,
    parameter int                    CLR_CYCLES = 2,
    parameter int                    OVF_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  synced_new_data_flag,
    input  logic [DATA_WIDTH-1:0] synced_data_received,
    output logic                  clear_new_data_flag,
    output logic [DATA_WIDTH-1:0] data_to_send,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [OVF_WIDTH-1:0]  overrun_count,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_CLEAR    = 2'd2,
        ST_WAIT_LOW = 2'd3
    } state_t;

    localparam int CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_clr_cnt;
    logic                  w_clr_done;
    logic                  r_clear;
    logic [DATA_WIDTH-1:0] r_tx_word;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_valid;
    logic                  w_capture;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push;

    assign w_capture  = (r_state == ST_CAPTURE);
    assign w_clr_done = (r_clr_cnt == CNT_W'(CLR_CYCLES - 1));
    assign w_pop      = r_rx_valid & rx_ready;
    assign w_full     = r_rx_valid & r_skid_valid;
    // A pop in the same cycle frees a slot, so a full buffer still accepts the push.
    assign w_push     = w_capture & (~w_full | w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (synced_new_data_flag) w_next_state = ST_CAPTURE;
            ST_CAPTURE:  w_next_state = ST_CLEAR;
            ST_CLEAR:    if (w_clr_done) w_next_state = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!synced_new_data_flag) w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // The clear goes to the slave's async flag reset, so it comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clr_cnt <= '0;
            r_clear   <= 1'b0;
            r_tx_word <= FILL_WORD;
        end else begin
            r_clr_cnt <= (r_state == ST_CLEAR) ? r_clr_cnt + CNT_W'(1) : '0;
            r_clear   <= (w_next_state == ST_CLEAR);
            if (w_capture) begin
                r_tx_word <= tx_valid ? tx_data : FILL_WORD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
        end else if (w_pop) begin
            if (r_skid_valid) begin
                r_rx_data <= r_skid_data;
                if (w_push) begin
                    r_skid_data <= synced_data_received;
                end else begin
                    r_skid_valid <= 1'b0;
                end
            end else if (w_push) begin
                r_rx_data <= synced_data_received;
            end else begin
                r_rx_valid <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_rx_valid) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= synced_data_received;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= synced_data_received;
            end
        end
    end

`ifdef SPI_WORD_BRIDGE_OVERRUN_CNT_EN
    logic                 w_drop;
    logic [OVF_WIDTH-1:0] r_ovf_cnt;

    assign w_drop = w_capture & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != '1)) begin
            r_ovf_cnt <= r_ovf_cnt + OVF_WIDTH'(1);
        end
    end

    assign overrun_count = r_ovf_cnt;
`else
    assign overrun_count = '0;
`endif

    assign clear_new_data_flag = r_clear;
    assign data_to_send        = r_tx_word;
    assign rx_data             = r_rx_data;
    assign rx_valid            = r_rx_valid;
    assign tx_ready            = w_capture;
    assign state_dbg           = r_state;

endmodule

// File: tb/tb_spi_word_bridge.sv
// Directed bench for spi_word_bridge: drives the slave-side flag/word and both streams,
// checks against hand-computed values.
module tb_spi_word_bridge;

    localparam int          DW   = 16;
    localparam logic [15:0] FILL = 16'h0000;
    localparam int          CLR  = 2;
    localparam int          OVF  = 8;

    logic           clk;
    logic           reset;
    logic           synced_new_data_flag;
    logic [DW-1:0]  synced_data_received;
    logic           clear_new_data_flag;
    logic [DW-1:0]  data_to_send;
    logic [DW-1:0]  rx_data;
    logic           rx_valid;
    logic           rx_ready;
    logic [DW-1:0]  tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [OVF-1:0] overrun_count;
    logic [1:0]     state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int tx_hs    = 0;
    int rx_pops  = 0;

    spi_word_bridge #(
        .DATA_WIDTH(DW),
        .FILL_WORD (FILL),
        .CLR_CYCLES(CLR),
        .OVF_WIDTH (OVF)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .synced_new_data_flag(synced_new_data_flag),
        .synced_data_received(synced_data_received),
        .clear_new_data_flag (clear_new_data_flag),
        .data_to_send        (data_to_send),
        .rx_data             (rx_data),
        .rx_valid            (rx_valid),
        .rx_ready            (rx_ready),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .overrun_count       (overrun_count),
        .state_dbg           (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change at negedges, so the values seen here are those of the next posedge.
    always @(negedge clk) begin
        if (reset && tx_valid && tx_ready) tx_hs++;
        if (reset && rx_valid && rx_ready) rx_pops++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ovf_exp(input int n);
`ifdef SPI_WORD_BRIDGE_OVERRUN_CNT_EN
        return (n > 255) ? 32'd255 : 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    task automatic finish_event();
        int w;
        w = 0;
        while (clear_new_data_flag && w < 20) begin
            w++;
            @(negedge clk);
        end
        check("clear_width", w, CLR);
        synced_new_data_flag = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("back_to_idle", state_dbg, 0);
    endtask

    task automatic word_event(input logic [15:0] d, input logic tv, input logic [15:0] td,
                              input bit chk_rx);
        @(negedge clk);
        synced_data_received = d;
        synced_new_data_flag = 1'b1;
        tx_valid             = tv;
        tx_data              = td;
        @(negedge clk);
        check("tx_ready_capture", tx_ready, 1);
        if (chk_rx) check("rx_valid_early", rx_valid, 0);
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_once", tx_ready, 0);
        check("data_to_send", data_to_send, tv ? td : FILL);
        check("clear_started", clear_new_data_flag, 1);
        if (chk_rx) begin
            check("rx_valid_lat", rx_valid, 1);
            check("rx_data_lat", rx_data, d);
        end
        finish_event();
    endtask

    initial begin
        int hs0;
        int pops0;
        reset                = 1'b0;
        synced_new_data_flag = 1'b0;
        synced_data_received = '0;
        rx_ready             = 1'b0;
        tx_data              = '0;
        tx_valid             = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clear", clear_new_data_flag, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_data_to_send", data_to_send, FILL);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_overrun", overrun_count, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single word, sorter always ready.
        rx_ready = 1'b1;
        word_event(16'hBEEF, 1'b0, 16'h0000, 1'b1);
        check("single_drained", rx_valid, 0);

        // Tx refill then fallback to fill word.
        hs0 = tx_hs;
        word_event(16'h1111, 1'b1, 16'h1234, 1'b1);
        check("refill_hs_count", tx_hs - hs0, 1);
        check("refill_hold", data_to_send, 16'h1234);
        word_event(16'h2222, 1'b0, 16'hFFFF, 1'b1);
        check("refill_fill", data_to_send, FILL);

        // Backpressure: two buffered, third dropped.
        rx_ready = 1'b0;
        word_event(16'hA001, 1'b0, 16'h0, 1'b0);
        word_event(16'hA002, 1'b0, 16'h0, 1'b0);
        word_event(16'hA003, 1'b0, 16'h0, 1'b0);
        check("bp_valid", rx_valid, 1);
        check("bp_head", rx_data, 16'hA001);
        check("bp_overrun", overrun_count, ovf_exp(1));
        rx_ready = 1'b1;
        @(negedge clk);
        check("bp_second_valid", rx_valid, 1);
        check("bp_second", rx_data, 16'hA002);
        @(negedge clk);
        check("bp_empty", rx_valid, 0);

        // Full buffer with a pop in the capture cycle: push succeeds, no overrun.
        rx_ready = 1'b0;
        word_event(16'hB001, 1'b0, 16'h0, 1'b0);
        word_event(16'hB002, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        synced_data_received = 16'hB003;
        synced_new_data_flag = 1'b1;
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("pp_head", rx_data, 16'hB002);
        check("pp_valid", rx_valid, 1);
        check("pp_overrun", overrun_count, ovf_exp(1));
        finish_event();
        check("pp_hold", rx_data, 16'hB002);
        rx_ready = 1'b1;
        @(negedge clk);
        check("pp_third", rx_data, 16'hB003);
        check("pp_third_valid", rx_valid, 1);
        @(negedge clk);
        check("pp_empty", rx_valid, 0);

        // Flag held high: exactly one capture, parked in WAIT_LOW.
        pops0 = rx_pops;
        synced_data_received = 16'hCAFE;
        synced_new_data_flag = 1'b1;
        repeat (50) @(negedge clk);
        check("held_one_word", rx_pops - pops0, 1);
        check("held_state", state_dbg, 3);
        check("held_clear_low", clear_new_data_flag, 0);
        synced_new_data_flag = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("held_release", state_dbg, 0);

        // Saturation of the overrun counter.
        rx_ready = 1'b0;
        word_event(16'hC001, 1'b0, 16'h0, 1'b0);
        word_event(16'hC002, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            word_event(16'(i), 1'b0, 16'h0, 1'b0);
        end
        check("sat_overrun", overrun_count, ovf_exp(301));
        check("sat_head", rx_data, 16'hC001);

        // Reset asserted in the middle of CLEAR.
        @(negedge clk);
        synced_data_received = 16'hD00D;
        synced_new_data_flag = 1'b1;
        tx_valid             = 1'b1;
        tx_data              = 16'h5A5A;
        @(negedge clk);
        @(negedge clk);
        check("mid_clear_high", clear_new_data_flag, 1);
        check("mid_tx_word", data_to_send, 16'h5A5A);
        reset = 1'b0;
        #1;
        check("mid_rst_clear", clear_new_data_flag, 0);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_data_to_send", data_to_send, FILL);
        check("mid_rst_tx_ready", tx_ready, 0);
        check("mid_rst_overrun", overrun_count, 0);
        check("mid_rst_state", state_dbg, 0);
        synced_new_data_flag = 1'b0;
        tx_valid             = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_state", state_dbg, 0);
        check("post_rst_rx_valid", rx_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
